piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 66 ++++++
 tb/tb_piso_serializer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, one bit per enabled clock out with frame qualifiers
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             s_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shifted;
  logic [CW-1:0] cnt, cnt_n;
  logic accept;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign accept  = p_valid && p_ready;
  // a final-bit accept reloads in place so the next word follows with no gap
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (accept) begin
        state_n = SHIFT;
        shreg_n = p_in;
        cnt_n   = '0;
      end
    end else if (s_en) begin
      if (cnt != LAST) begin
        shreg_n = shifted;
        cnt_n   = cnt + 1'b1;
      end else begin
        state_n = accept ? SHIFT : IDLE;
        shreg_n = accept ? p_in : '0;
        cnt_n   = '0;
      end
    end
  end
  always_comb begin
    s_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    s_valid = state == SHIFT;
    busy    = state == SHIFT;
    s_last  = (state == SHIFT) && (cnt == LAST);
    p_ready = !rst && ((state == IDLE) || ((state == SHIFT) && (cnt == LAST) && s_en));
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of handshake, framing, stall and reset behaviour
module tb_piso_serializer;
  logic clk = 0, rst = 1, s_en = 1;
  logic [3:0] p_in_a = 0, p_in_b = 0;
  logic [7:0] p_in_c = 0;
  logic pv_a = 0, pv_b = 0, pv_c = 0;
  logic pr_a, so_a, sv_a, sl_a, bz_a;
  logic pr_b, so_b, sv_b, sl_b, bz_b;
  logic pr_c, so_c, sv_c, sl_c, bz_c;
  int total = 0, bad = 0;
  logic [7:0] pat;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .p_in(p_in_a), .p_valid(pv_a), .p_ready(pr_a), .s_en(s_en),
    .s_out(so_a), .s_valid(sv_a), .s_last(sl_a), .busy(bz_a));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .p_in(p_in_b), .p_valid(pv_b), .p_ready(pr_b), .s_en(s_en),
    .s_out(so_b), .s_valid(sv_b), .s_last(sl_b), .busy(bz_b));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .p_in(p_in_c), .p_valid(pv_c), .p_ready(pr_c), .s_en(s_en),
    .s_out(so_c), .s_valid(sv_c), .s_last(sl_c), .busy(bz_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_pready", {31'b0, pr_a}, 0);
    chk("rst_svalid", {31'b0, sv_a}, 0);
    chk("rst_sout", {31'b0, so_a}, 0);
    step;
    rst = 0;
    #1;
    chk("idle_pready", {31'b0, pr_a}, 1);
    chk("idle_busy", {31'b0, bz_a}, 0);

    p_in_a = 4'b1010; pv_a = 1;
    step;
    pv_a = 0;
    pat = 8'b1010_0000;
    for (int i = 0; i < 4; i++) begin
      chk("single_sout", {31'b0, so_a}, {31'b0, pat[7-i]});
      chk("single_svalid", {31'b0, sv_a}, 1);
      chk("single_busy", {31'b0, bz_a}, 1);
      chk("single_slast", {31'b0, sl_a}, {31'b0, i == 3});
      step;
    end
    chk("single_end", {31'b0, sv_a}, 0);

    p_in_a = 4'b1100; pv_a = 1;
    step;
    p_in_a = 4'b0011;
    pat = 8'b1100_0011;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pv_a = 0;
      chk("b2b_sout", {31'b0, so_a}, {31'b0, pat[7-i]});
      chk("b2b_svalid", {31'b0, sv_a}, 1);
      chk("b2b_slast", {31'b0, sl_a}, {31'b0, i == 3 || i == 7});
      if (i < 7) chk("b2b_pready", {31'b0, pr_a}, {31'b0, i == 3});
      step;
    end
    chk("b2b_end", {31'b0, sv_a}, 0);

    p_in_a = 4'b1001; pv_a = 1;
    step;
    pv_a = 0;
    chk("stall_first", {31'b0, so_a}, 1);
    s_en = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (i == 0) begin p_in_a = 4'b1111; pv_a = 1; end
      if (i == 2) begin pv_a = 0; s_en = 1; end
      chk("stall_sout", {31'b0, so_a}, 1);
      chk("stall_svalid", {31'b0, sv_a}, 1);
      chk("stall_slast", {31'b0, sl_a}, 0);
      chk("stall_pready", {31'b0, pr_a}, 0);
    end
    pat = 8'b0010_0000;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_tail", {31'b0, so_a}, {31'b0, pat[7-i]});
      chk("stall_tlast", {31'b0, sl_a}, {31'b0, i == 2});
    end
    step;
    chk("stall_end", {31'b0, sv_a}, 0);

    p_in_b = 4'b0011; pv_b = 1;
    step;
    pv_b = 0;
    pat = 8'b1100_0000;
    for (int i = 0; i < 4; i++) begin
      chk("lsb_sout", {31'b0, so_b}, {31'b0, pat[7-i]});
      chk("lsb_slast", {31'b0, sl_b}, {31'b0, i == 3});
      step;
    end
    chk("lsb_end", {31'b0, sv_b}, 0);

    p_in_c = 8'hA5; pv_c = 1;
    step;
    pv_c = 0;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("w8_sout", {31'b0, so_c}, {31'b0, pat[7-i]});
      chk("w8_slast", {31'b0, sl_c}, {31'b0, i == 7});
      step;
    end
    chk("w8_end", {31'b0, sv_c}, 0);

    p_in_a = 4'b1111; pv_a = 1;
    step;
    pv_a = 0;
    chk("mid_b1", {31'b0, so_a}, 1);
    step;
    chk("mid_b2", {31'b0, so_a}, 1);
    #2;
    rst = 1;
    #1;
    chk("mid_svalid", {31'b0, sv_a}, 0);
    chk("mid_sout", {31'b0, so_a}, 0);
    chk("mid_slast", {31'b0, sl_a}, 0);
    chk("mid_busy", {31'b0, bz_a}, 0);
    chk("mid_pready", {31'b0, pr_a}, 0);
    step;
    rst = 0;
    #1;
    chk("post_pready", {31'b0, pr_a}, 1);
    chk("post_svalid", {31'b0, sv_a}, 0);
    p_in_a = 4'b0101; pv_a = 1;
    step;
    pv_a = 0;
    pat = 8'b0101_0000;
    for (int i = 0; i < 4; i++) begin
      chk("post_sout", {31'b0, so_a}, {31'b0, pat[7-i]});
      chk("post_slast", {31'b0, sl_a}, {31'b0, i == 3});
      step;
    end
    chk("post_end", {31'b0, sv_a}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
